// File: rtl/trivium_pkg.sv
// Shared Trivium constants: widths, slice sizes, slice-local tap positions (1-based) and FSM states.
package trivium_pkg;
  localparam int KEY_W   = 80;
  localparam int IV_W    = 80;
  localparam int STATE_W = 288;

  localparam int A_SZ = 93;
  localparam int B_SZ = 84;
  localparam int C_SZ = 111;

  // Taps counted from the first bit of each slice: s66/s69/s91 in A, s162/s171/s175 in B, s243/s264/s286 in C
  localparam int FF_A = 66, FB_A = 69, AND_A = 91;
  localparam int FF_B = 69, FB_B = 78, AND_B = 82;
  localparam int FF_C = 66, FB_C = 87, AND_C = 109;

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} trv_state_e;
endpackage

// File: rtl/trivium_keystream_core_slice.sv
// One Trivium NLFSR slice advanced STEPS bit-steps per enable; r_sr[i] holds slice bit i+1.
module triv_nlfsr_slice
  import trivium_pkg::*;
#(
  parameter int REG_SZ        = A_SZ,
  parameter int FEED_FWD_IDX  = FF_A,
  parameter int FEED_BKWD_IDX = FB_A,
  parameter int AND_IDX       = AND_A,
  parameter int STEPS         = 8
) (
  input  logic              clk_i,
  input  logic              n_rst_i,
  input  logic              i_load,
  input  logic              i_adv,
  input  logic [REG_SZ-1:0] i_load_val,
  input  logic [STEPS-1:0]  i_nb_t,
  input  logic [STEPS-1:0]  i_nb_and,
  output logic [STEPS-1:0]  o_t,
  output logic [STEPS-1:0]  o_and
);
  logic [REG_SZ-1:0] r_sr;
  logic [STEPS-1:0]  w_fb_rev;

  // Every tap sits further in than STEPS, so step k reads the pre-advance register shifted by k.
  for (genvar k = 0; k < STEPS; k++) begin : g_step
    assign o_t[k]              = r_sr[FEED_FWD_IDX-1-k] ^ r_sr[REG_SZ-1-k];
    assign o_and[k]            = r_sr[AND_IDX-1-k] & r_sr[AND_IDX-k];
    assign w_fb_rev[STEPS-1-k] = i_nb_t[k] ^ i_nb_and[k] ^ r_sr[FEED_BKWD_IDX-1-k];
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i)    r_sr <= '0;
    else if (i_load) r_sr <= i_load_val;
    else if (i_adv)  r_sr <= {r_sr[REG_SZ-1-STEPS:0], w_fb_rev};
  end
endmodule

// File: rtl/trivium_keystream_core.sv
// Trivium keystream generator: three NLFSR slices, warm-up FSM and a valid/ready output register.
module trivium_keystream_core
  import trivium_pkg::*;
#(
  parameter int BITS_PER_CYC  = 8,
  parameter int WARMUP_ROUNDS = 4
) (
  input  logic                    clk_i,
  input  logic                    n_rst_i,
  input  logic                    start_i,
  input  logic                    stop_i,
  input  logic [KEY_W-1:0]        key_i,
  input  logic [IV_W-1:0]         iv_i,
  output logic                    busy_o,
  output logic                    ks_vld_o,
  input  logic                    ks_rdy_i,
  output logic [BITS_PER_CYC-1:0] ks_dat_o
);
  localparam int BPC   = BITS_PER_CYC;
  localparam int N     = WARMUP_ROUNDS * STATE_W / BPC;
  localparam int CNT_W = $clog2(N + 1);

  if (BPC < 1 || BPC > 64 || (BPC & (BPC - 1)) != 0) begin : g_bad_bpc
    $error("BITS_PER_CYC must be a power of two in 1..64");
  end
  if (WARMUP_ROUNDS < 1 || (WARMUP_ROUNDS * STATE_W) % BPC != 0) begin : g_bad_warm
    $error("WARMUP_ROUNDS*288 must be a positive multiple of BITS_PER_CYC");
  end

  trv_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_vld;
  logic [BPC-1:0]   r_dat;
  logic             w_load, w_adv, w_emit;
  logic [BPC-1:0]   w_ta, w_tb, w_tc, w_aa, w_ab, w_ac, w_z;

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_adv       = 1'b0;
    w_emit      = 1'b0;
    if (start_i) begin
      w_load      = 1'b1;
      w_state_nxt = WARMUP;
    end else if (stop_i) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        WARMUP: begin
          w_adv = 1'b1;
          if (r_cnt == CNT_W'(N - 1)) w_state_nxt = RUN;
        end
        RUN: if (!r_vld || ks_rdy_i) begin
          w_adv  = 1'b1;
          w_emit = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_vld <= 1'b0;
      r_dat <= '0;
      r_cnt <= '0;
    end else begin
      if (w_load || stop_i)       r_vld <= 1'b0;
      else if (w_emit)            r_vld <= 1'b1;
      else if (r_vld && ks_rdy_i) r_vld <= 1'b0;
      if (w_emit) r_dat <= w_z;
      // Saturating, so a stray extra WARMUP cycle can never wrap back to zero.
      if (w_load)                                          r_cnt <= '0;
      else if (w_adv && r_state == WARMUP && r_cnt != CNT_W'(N)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  triv_nlfsr_slice #(.REG_SZ(A_SZ), .FEED_FWD_IDX(FF_A), .FEED_BKWD_IDX(FB_A), .AND_IDX(AND_A), .STEPS(BPC)) u_sa (
    .clk_i(clk_i), .n_rst_i(n_rst_i), .i_load(w_load), .i_adv(w_adv),
    .i_load_val({{(A_SZ-KEY_W){1'b0}}, key_i}),
    .i_nb_t(w_tc), .i_nb_and(w_ac), .o_t(w_ta), .o_and(w_aa));

  triv_nlfsr_slice #(.REG_SZ(B_SZ), .FEED_FWD_IDX(FF_B), .FEED_BKWD_IDX(FB_B), .AND_IDX(AND_B), .STEPS(BPC)) u_sb (
    .clk_i(clk_i), .n_rst_i(n_rst_i), .i_load(w_load), .i_adv(w_adv),
    .i_load_val({{(B_SZ-IV_W){1'b0}}, iv_i}),
    .i_nb_t(w_ta), .i_nb_and(w_aa), .o_t(w_tb), .o_and(w_ab));

  triv_nlfsr_slice #(.REG_SZ(C_SZ), .FEED_FWD_IDX(FF_C), .FEED_BKWD_IDX(FB_C), .AND_IDX(AND_C), .STEPS(BPC)) u_sc (
    .clk_i(clk_i), .n_rst_i(n_rst_i), .i_load(w_load), .i_adv(w_adv),
    .i_load_val({3'b111, {(C_SZ-3){1'b0}}}),
    .i_nb_t(w_tb), .i_nb_and(w_ab), .o_t(w_tc), .o_and(w_ac));

  assign w_z      = w_ta ^ w_tb ^ w_tc;
  assign busy_o   = (r_state != IDLE);
  assign ks_vld_o = r_vld;
  assign ks_dat_o = r_dat;
endmodule

// File: tb/tb_trivium_keystream_core.sv
// Scoreboard bench: a bit-serial Trivium model fills the expected-word queue at every start.
module tb_trivium_keystream_core;
  localparam int BPC = 8;
  localparam int LAT = 145;
  localparam int QW  = 1024;

  logic           clk_i = 1'b0;
  logic           n_rst_i = 1'b0;
  logic           start_i = 1'b0, stop_i = 1'b0, ks_rdy_i = 1'b0;
  logic [79:0]    key_i = '0, iv_i = '0;
  logic           busy_o, ks_vld_o;
  logic [BPC-1:0] ks_dat_o;

  int n_tot = 0, n_bad = 0;
  logic [288:1] ms;
  logic [BPC-1:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  trivium_keystream_core #(.BITS_PER_CYC(BPC), .WARMUP_ROUNDS(4)) dut (
    .clk_i(clk_i), .n_rst_i(n_rst_i), .start_i(start_i), .stop_i(stop_i),
    .key_i(key_i), .iv_i(iv_i), .busy_o(busy_o), .ks_vld_o(ks_vld_o),
    .ks_rdy_i(ks_rdy_i), .ks_dat_o(ks_dat_o));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic model_step(output logic z);
    logic t1, t2, t3;
    t1 = ms[66] ^ ms[93];
    t2 = ms[162] ^ ms[177];
    t3 = ms[243] ^ ms[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
    t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
    t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
    ms[93:1]    = {ms[92:1], t3};
    ms[177:94]  = {ms[176:94], t1};
    ms[288:178] = {ms[287:178], t2};
  endtask

  task automatic load_expected(input logic [79:0] k, input logic [79:0] v);
    logic z;
    logic [BPC-1:0] w;
    ms = '0;
    ms[80:1] = k;
    ms[173:94] = v;
    ms[288:286] = 3'b111;
    for (int i = 0; i < 4 * 288; i++) model_step(z);
    exp_q.delete();
    for (int n = 0; n < QW; n++) begin
      for (int b = 0; b < BPC; b++) begin
        model_step(z);
        w[b] = z;
      end
      exp_q.push_back(w);
    end
  endtask

  task automatic start_and_wait(input logic [79:0] k, input logic [79:0] v, input logic with_stop);
    int lat;
    key_i = k; iv_i = v; start_i = 1'b1; stop_i = with_stop; ks_rdy_i = 1'b1;
    tick();
    start_i = 1'b0; stop_i = 1'b0;
    chk("vld_after_start", 64'(ks_vld_o), 64'd0);
    chk("busy_after_start", 64'(busy_o), 64'd1);
    load_expected(k, v);
    lat = 0;
    while (!ks_vld_o && lat < 400) begin
      tick();
      lat++;
    end
    chk("latency", 64'(lat), 64'(LAT));
  endtask

  task automatic get_words(input int n, input logic rnd);
    int got, cyc;
    logic held_v;
    logic [BPC-1:0] held_d, exp;
    got = 0; cyc = 0; held_v = 1'b0; held_d = '0;
    while (got < n && cyc < n * 20 + 50) begin
      ks_rdy_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (held_v) begin
        chk("hold_vld", 64'(ks_vld_o), 64'd1);
        chk("hold_dat", 64'(ks_dat_o), 64'(held_d));
      end
      if (ks_vld_o && ks_rdy_i) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : ~ks_dat_o;
        chk("word", 64'(ks_dat_o), 64'(exp));
        got++;
      end
      held_v = ks_vld_o && !ks_rdy_i;
      held_d = ks_dat_o;
      tick();
      cyc++;
    end
    if (got < n) chk("words_timeout", 64'(got), 64'(n));
  endtask

  function automatic logic [79:0] rnd80();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[79:0];
  endfunction

  initial begin
    #1;
    chk("rst_vld", 64'(ks_vld_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_dat", 64'(ks_dat_o), 64'd0);
    tick();
    n_rst_i = 1'b1;
    tick();
    chk("idle_busy", 64'(busy_o), 64'd0);

    // all-zero key/iv, continuous ready
    start_and_wait('0, '0, 1'b0);
    get_words(64, 1'b0);

    // random key/iv with random backpressure
    start_and_wait(rnd80(), rnd80(), 1'b0);
    get_words(1000, 1'b1);

    // restart mid-WARMUP, then mid-RUN
    key_i = rnd80(); iv_i = rnd80(); start_i = 1'b1; ks_rdy_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (50) tick();
    chk("warm_busy", 64'(busy_o), 64'd1);
    start_and_wait(rnd80(), rnd80(), 1'b0);
    get_words(20, 1'b0);
    chk("run_vld_before_restart", 64'(ks_vld_o), 64'd1);
    start_and_wait(rnd80(), rnd80(), 1'b0);
    get_words(20, 1'b0);

    // stop alone in RUN
    stop_i = 1'b1;
    tick();
    stop_i = 1'b0;
    chk("stop_busy", 64'(busy_o), 64'd0);
    chk("stop_vld", 64'(ks_vld_o), 64'd0);
    repeat (5) tick();
    chk("stop_idle_busy", 64'(busy_o), 64'd0);
    chk("stop_idle_vld", 64'(ks_vld_o), 64'd0);

    // start and stop together: start wins
    start_and_wait(rnd80(), rnd80(), 1'b1);
    get_words(20, 1'b0);

    // async reset in the middle of RUN
    #2;
    n_rst_i = 1'b0;
    #1;
    chk("arst_vld", 64'(ks_vld_o), 64'd0);
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_dat", 64'(ks_dat_o), 64'd0);
    tick();
    n_rst_i = 1'b1;
    repeat (4) tick();
    chk("post_rst_busy", 64'(busy_o), 64'd0);
    chk("post_rst_vld", 64'(ks_vld_o), 64'd0);
    start_and_wait(rnd80(), rnd80(), 1'b0);
    get_words(10, 1'b0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
